// File: rtl/mux_4_1_pkg.sv
// Shared definitions for the registered 4-to-1 multiplexer:
// select-code type and constants, default data width.
package mux_4_1_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned SEL_WIDTH  = 2;

    typedef logic [SEL_WIDTH-1:0] sel_t;

    localparam sel_t SEL_IN1 = 2'd0;
    localparam sel_t SEL_IN2 = 2'd1;
    localparam sel_t SEL_IN3 = 2'd2;
    localparam sel_t SEL_IN4 = 2'd3;

endpackage : mux_4_1_pkg

// File: rtl/mux_4_1_if.sv
// Bus bundle for mux_4_1.
//   in1..in4 : candidate data words (WIDTH bits each)
//   sel      : select code (in1..in4 for codes 0..3)
//   en       : load enable for the output register
//   ou1      : registered selected word
//   valid    : high once ou1 holds a word loaded since reset
// master drives data/select/enable; slave (the mux) drives ou1/valid.
interface mux_4_1_if
    import mux_4_1_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
);

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    sel_t             sel;
    logic             en;
    logic [WIDTH-1:0] ou1;
    logic             valid;

    modport master (
        output in1,
        output in2,
        output in3,
        output in4,
        output sel,
        output en,
        input  ou1,
        input  valid
    );

    modport slave (
        input  in1,
        input  in2,
        input  in3,
        input  in4,
        input  sel,
        input  en,
        output ou1,
        output valid
    );

endinterface : mux_4_1_if

// File: rtl/mux_4_1_sel.sv
// Purely combinational word selector.
//   in1_i..in4_i : candidate words
//   sel_i        : select code
//   word_c_o     : selected word (combinational)
module mux_4_1_sel
    import mux_4_1_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    input  logic [WIDTH-1:0] in4_i,
    input  sel_t             sel_i,
    output logic [WIDTH-1:0] word_c_o
);

    // All four codes are legal, so the case is full without a default arm.
    always_comb begin
        word_c_o = in1_i;
        unique case (sel_i)
            SEL_IN1: word_c_o = in1_i;
            SEL_IN2: word_c_o = in2_i;
            SEL_IN3: word_c_o = in3_i;
            SEL_IN4: word_c_o = in4_i;
        endcase
    end

endmodule : mux_4_1_sel

// File: rtl/mux_4_1.sv
// Registered 4-to-1 multiplexer: selected word lands on ou1 one clock
// after sampling when en is high; valid flags the first load since reset.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (clears ou1 and valid)
//   bus   : mux_4_1_if slave (in1..in4, sel, en in; ou1, valid out)
module mux_4_1
    import mux_4_1_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_4_1_if.slave  bus
);

    logic [WIDTH-1:0] word_c;
    logic [WIDTH-1:0] ou1_d;
    logic [WIDTH-1:0] ou1_q;
    logic             valid_d;
    logic             valid_q;

    mux_4_1_sel #(
        .WIDTH    (WIDTH)
    ) u_sel (
        .in1_i    (bus.in1),
        .in2_i    (bus.in2),
        .in3_i    (bus.in3),
        .in4_i    (bus.in4),
        .sel_i    (bus.sel),
        .word_c_o (word_c)
    );

    // Enable-gated next state; hold otherwise.
    always_comb begin
        ou1_d   = ou1_q;
        valid_d = valid_q;
        if (bus.en) begin
            ou1_d   = word_c;
            valid_d = 1'b1;
        end
    end

    // Output register; reset dominates any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ou1_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ou1_q   <= ou1_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ou1   = ou1_q;
    assign bus.valid = valid_q;

endmodule : mux_4_1

// File: tb/tb_mux_4_1.sv
// Scoreboard bench for mux_4_1: each driven cycle pushes the expected
// {valid, ou1}; the value is popped and compared one edge later.
module tb_mux_4_1;
    import mux_4_1_pkg::*;

    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;

    mux_4_1_if #(.WIDTH(W)) bus ();

    mux_4_1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [W:0] sb_q[$];
    logic [W-1:0] m_ou1;
    logic         m_valid;

    task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got valid=%b ou1=%h, expected valid=%b ou1=%h",
                     tag, obs[W], obs[W-1:0], exp[W], exp[W-1:0]);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] s);
        if (s == 2'd0) return bus.in1;
        else if (s == 2'd1) return bus.in2;
        else if (s == 2'd2) return bus.in3;
        else return bus.in4;
    endfunction

    // Called with inputs already set; pushes expectation, samples after edge.
    task automatic cycle(input string tag);
        logic [W:0] exp;
        if (rst_n && bus.en) begin
            m_ou1   = pick(bus.sel);
            m_valid = 1'b1;
        end else if (!rst_n) begin
            m_ou1   = '0;
            m_valid = 1'b0;
        end
        sb_q.push_back({m_valid, m_ou1});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check_eq(tag, {bus.valid, bus.ou1}, exp);
        @(negedge clk);
    endtask

    task automatic set_ins(input logic [W-1:0] a, b, c, d);
        bus.in1 = a;
        bus.in2 = b;
        bus.in3 = c;
        bus.in4 = d;
    endtask

    initial begin
        rst_n   = 1'b1;
        bus.en  = 1'b0;
        bus.sel = SEL_IN1;
        set_ins('0, '0, '0, '0);
        m_ou1   = '0;
        m_valid = 1'b0;

        // Asynchronous reset between edges with en high.
        bus.en  = 1'b1;
        bus.in1 = 32'hFFFF_FFFF;
        #3;
        rst_n = 1'b0;
        #1;
        m_ou1   = '0;
        m_valid = 1'b0;
        check_eq("rst_async", {bus.valid, bus.ou1}, {1'b0, 32'h0});
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle("rst_hold");
        rst_n = 1'b1;

        // Select sweep, two cycles per code.
        set_ins(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
        bus.en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            cycle("sweep");
            cycle("sweep");
        end

        // Distinct words, sel stepping 3..0.
        set_ins(32'h1111_1111, 32'h2222_2222, 32'hA5A5_A5A5, 32'h8000_0001);
        for (int s = 3; s >= 0; s--) begin
            bus.sel = 2'(s);
            cycle("distinct");
        end

        // Enable hold.
        bus.sel = SEL_IN2;
        cycle("hold_load");
        bus.en  = 1'b0;
        bus.sel = SEL_IN4;
        bus.in2 = 32'h0;
        for (int i = 0; i < 3; i++) cycle("hold");
        bus.en = 1'b1;
        cycle("hold_release");
        bus.in2 = 32'h2222_2222;

        // Unselected inputs toggling must not disturb ou1.
        bus.sel = SEL_IN3;
        for (int i = 0; i < 4; i++) begin
            bus.in1 = ~bus.in1;
            bus.in2 = ~bus.in2;
            bus.in4 = ~bus.in4;
            cycle("isolate");
        end
        set_ins(32'h1111_1111, 32'h2222_2222, 32'hA5A5_A5A5, 32'h8000_0001);

        // Mid-stream reset pulse, then first load after release.
        bus.sel = SEL_IN4;
        cycle("pre_rst");
        #1;
        rst_n   = 1'b0;
        bus.sel = SEL_IN1;
        #1;
        m_ou1   = '0;
        m_valid = 1'b0;
        check_eq("rst_mid", {bus.valid, bus.ou1}, {1'b0, 32'h0});
        #2;
        rst_n = 1'b1;
        #0.5;
        check_eq("rst_release", {bus.valid, bus.ou1}, {1'b0, 32'h0});
        cycle("post_rst");
        cycle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_mux_4_1
